// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: two one-entry writeback buffers (A = ALU, B = load)
// share one write port with fixed priority, B starvation override and same-register age order.
module rf_wr_arbiter #(
    parameter int DATA_W     = 16,
    parameter int SEL_W      = 3,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a_valid,
    input  logic [SEL_W-1:0]  req_a_reg,
    input  logic [DATA_W-1:0] req_a_data,
    output logic              req_a_ready,
    input  logic              req_b_valid,
    input  logic [SEL_W-1:0]  req_b_reg,
    input  logic [DATA_W-1:0] req_b_data,
    output logic              req_b_ready,
    input  logic [SEL_W-1:0]  read1_reg_sel,
    input  logic [SEL_W-1:0]  read2_reg_sel,
    output logic              pend1_hit,
    output logic              pend2_hit,
    output logic [DATA_W-1:0] pend1_data,
    output logic [DATA_W-1:0] pend2_data,
    output logic              rf_write,
    output logic [SEL_W-1:0]  rf_write_reg_sel,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              busy
);

    localparam int STARVE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

    logic                a_full_r, b_full_r;
    logic [SEL_W-1:0]    a_reg_r, b_reg_r;
    logic [DATA_W-1:0]   a_data_r, b_data_r;
    logic                older_r;            // 1: bufB holds the older write
    logic [STARVE_W-1:0] starve_r;

    logic grant_a_s, grant_b_s, load_a_s, load_b_s;
    logic [DATA_W:0] fwd1_s, fwd2_s;

    // When both buffers hold the same register the younger one reflects program order.
    function automatic logic [DATA_W:0] fwd_pick(
        input logic [SEL_W-1:0]  sel,
        input logic              a_full,
        input logic [SEL_W-1:0]  a_reg,
        input logic [DATA_W-1:0] a_data,
        input logic              b_full,
        input logic [SEL_W-1:0]  b_reg,
        input logic [DATA_W-1:0] b_data,
        input logic              b_older
    );
        logic hit_a, hit_b;
        hit_a = a_full && (a_reg == sel);
        hit_b = b_full && (b_reg == sel);
        if (hit_a && hit_b) begin
            fwd_pick = b_older ? {1'b1, a_data} : {1'b1, b_data};
        end else if (hit_a) begin
            fwd_pick = {1'b1, a_data};
        end else if (hit_b) begin
            fwd_pick = {1'b1, b_data};
        end else begin
            fwd_pick = {1'b0, {DATA_W{1'b0}}};
        end
    endfunction

    // Grant selection: age order on a shared register beats the starvation override.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (a_full_r && b_full_r) begin
            if (a_reg_r == b_reg_r) begin
                grant_b_s = older_r;
                grant_a_s = !older_r;
            end else if (starve_r == STARVE_W'(STARVE_MAX)) begin
                grant_b_s = 1'b1;
            end else begin
                grant_a_s = 1'b1;
            end
        end else if (a_full_r) begin
            grant_a_s = 1'b1;
        end else if (b_full_r) begin
            grant_b_s = 1'b1;
        end else begin
            grant_a_s = 1'b0;
        end
    end

    assign req_a_ready = !a_full_r || grant_a_s;
    assign req_b_ready = !b_full_r || grant_b_s;
    assign load_a_s    = req_a_valid && req_a_ready;
    assign load_b_s    = req_b_valid && req_b_ready;
    assign busy        = a_full_r || b_full_r;

    // Write port driven straight from the granted buffer; zeros when idle.
    always_comb begin
        rf_write         = grant_a_s || grant_b_s;
        rf_write_reg_sel = {SEL_W{1'b0}};
        rf_write_data    = {DATA_W{1'b0}};
        if (grant_a_s) begin
            rf_write_reg_sel = a_reg_r;
            rf_write_data    = a_data_r;
        end else if (grant_b_s) begin
            rf_write_reg_sel = b_reg_r;
            rf_write_data    = b_data_r;
        end else begin
            rf_write_reg_sel = {SEL_W{1'b0}};
        end
    end

    assign fwd1_s     = fwd_pick(read1_reg_sel, a_full_r, a_reg_r, a_data_r,
                                 b_full_r, b_reg_r, b_data_r, older_r);
    assign fwd2_s     = fwd_pick(read2_reg_sel, a_full_r, a_reg_r, a_data_r,
                                 b_full_r, b_reg_r, b_data_r, older_r);
    assign pend1_hit  = fwd1_s[DATA_W];
    assign pend1_data = fwd1_s[DATA_W-1:0];
    assign pend2_hit  = fwd2_s[DATA_W];
    assign pend2_data = fwd2_s[DATA_W-1:0];

    // Buffer, age and starvation state; a reload at the drain edge keeps the buffer full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_full_r <= 1'b0;
            a_reg_r  <= {SEL_W{1'b0}};
            a_data_r <= {DATA_W{1'b0}};
            b_full_r <= 1'b0;
            b_reg_r  <= {SEL_W{1'b0}};
            b_data_r <= {DATA_W{1'b0}};
            older_r  <= 1'b0;
            starve_r <= {STARVE_W{1'b0}};
        end else begin
            if (load_a_s) begin
                a_full_r <= 1'b1;
                a_reg_r  <= req_a_reg;
                a_data_r <= req_a_data;
            end else if (grant_a_s) begin
                a_full_r <= 1'b0;
            end
            if (load_b_s) begin
                b_full_r <= 1'b1;
                b_reg_r  <= req_b_reg;
                b_data_r <= req_b_data;
            end else if (grant_b_s) begin
                b_full_r <= 1'b0;
            end
            if (load_a_s && load_b_s) begin
                older_r <= 1'b0;
            end else if (load_a_s) begin
                older_r <= 1'b1;
            end else if (load_b_s) begin
                older_r <= 1'b0;
            end
            if (b_full_r && !grant_b_s) begin
                if (starve_r != STARVE_W'(STARVE_MAX)) begin
                    starve_r <= starve_r + STARVE_W'(1);
                end
            end else begin
                starve_r <= {STARVE_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: a queue-of-pending-writes model ordered by program sequence
// number, checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_rf_wr_arbiter;

    localparam int DATA_W     = 16;
    localparam int SEL_W      = 3;
    localparam int STARVE_MAX = 3;

    logic              clk;
    logic              rst_n;
    logic              req_a_valid, req_b_valid;
    logic [SEL_W-1:0]  req_a_reg, req_b_reg;
    logic [DATA_W-1:0] req_a_data, req_b_data;
    logic              req_a_ready, req_b_ready;
    logic [SEL_W-1:0]  read1_reg_sel, read2_reg_sel;
    logic              pend1_hit, pend2_hit;
    logic [DATA_W-1:0] pend1_data, pend2_data;
    logic              rf_write;
    logic [SEL_W-1:0]  rf_write_reg_sel;
    logic [DATA_W-1:0] rf_write_data;
    logic              busy;

    rf_wr_arbiter #(.DATA_W(DATA_W), .SEL_W(SEL_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a_valid(req_a_valid), .req_a_reg(req_a_reg), .req_a_data(req_a_data),
        .req_a_ready(req_a_ready),
        .req_b_valid(req_b_valid), .req_b_reg(req_b_reg), .req_b_data(req_b_data),
        .req_b_ready(req_b_ready),
        .read1_reg_sel(read1_reg_sel), .read2_reg_sel(read2_reg_sel),
        .pend1_hit(pend1_hit), .pend2_hit(pend2_hit),
        .pend1_data(pend1_data), .pend2_data(pend2_data),
        .rf_write(rf_write), .rf_write_reg_sel(rf_write_reg_sel),
        .rf_write_data(rf_write_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: outstanding writes in program order, plus the register-file image.
    typedef struct {
        bit                src_b;
        logic [SEL_W-1:0]  rg;
        logic [DATA_W-1:0] d;
        int                seq;
    } pend_t;

    pend_t             q[$];
    logic [DATA_W-1:0] model_rf[8];
    logic [DATA_W-1:0] prog_rf[8];
    int                wait_b = 0;
    int                seq_n  = 0;

    initial begin
        for (int i = 0; i < 8; i++) begin
            model_rf[i] = '0;
            prog_rf[i]  = '0;
        end
    end

    function automatic void fwd(input logic [SEL_W-1:0] sel, output bit hit,
                                output logic [DATA_W-1:0] d);
        int best;
        best = -1;
        hit  = 1'b0;
        d    = '0;
        foreach (q[i]) begin
            if (q[i].rg == sel && q[i].seq > best) begin
                best = q[i].seq;
                hit  = 1'b1;
                d    = q[i].d;
            end
        end
    endfunction

    // Per-cycle compare against the model, then advance the model past the coming edge.
    always @(negedge clk) begin
        int ia, ib, win;
        bit ea, eb, h1, h2;
        logic [DATA_W-1:0] f1, f2, v1, v2;
        pend_t e;
        if (rst_n) begin
            ia = -1;
            ib = -1;
            foreach (q[i]) begin
                if (q[i].src_b) ib = i;
                else ia = i;
            end
            win = -1;
            if (ia >= 0 && ib >= 0) begin
                if (q[ia].rg == q[ib].rg) win = (q[ia].seq < q[ib].seq) ? ia : ib;
                else win = (wait_b >= STARVE_MAX) ? ib : ia;
            end else if (ia >= 0) begin
                win = ia;
            end else if (ib >= 0) begin
                win = ib;
            end
            ea = (ia < 0) || (win == ia);
            eb = (ib < 0) || (win == ib);
            fwd(read1_reg_sel, h1, f1);
            fwd(read2_reg_sel, h2, f2);
            chk("ready_a", 32'(req_a_ready), 32'(ea));
            chk("ready_b", 32'(req_b_ready), 32'(eb));
            chk("rf_write", 32'(rf_write), 32'(win >= 0));
            chk("wr_sel", 32'(rf_write_reg_sel), (win >= 0) ? 32'(q[win].rg) : 32'd0);
            chk("wr_data", 32'(rf_write_data), (win >= 0) ? 32'(q[win].d) : 32'd0);
            chk("pend1_hit", 32'(pend1_hit), 32'(h1));
            chk("pend1_data", 32'(pend1_data), 32'(f1));
            chk("pend2_hit", 32'(pend2_hit), 32'(h2));
            chk("pend2_data", 32'(pend2_data), 32'(f2));
            chk("busy", 32'(busy), 32'(q.size() > 0));
            v1 = pend1_hit ? pend1_data : model_rf[read1_reg_sel];
            v2 = pend2_hit ? pend2_data : model_rf[read2_reg_sel];
            chk("view1", 32'(v1), 32'(prog_rf[read1_reg_sel]));
            chk("view2", 32'(v2), 32'(prog_rf[read2_reg_sel]));
            if (win >= 0) model_rf[q[win].rg] = q[win].d;
            if (ib >= 0 && win != ib) wait_b = (wait_b < STARVE_MAX) ? wait_b + 1 : STARVE_MAX;
            else wait_b = 0;
            if (win >= 0) q.delete(win);
            if (req_a_valid && ea) begin
                e.src_b = 1'b0; e.rg = req_a_reg; e.d = req_a_data; e.seq = seq_n++;
                q.push_back(e);
                prog_rf[req_a_reg] = req_a_data;
            end
            if (req_b_valid && eb) begin
                e.src_b = 1'b1; e.rg = req_b_reg; e.d = req_b_data; e.seq = seq_n++;
                q.push_back(e);
                prog_rf[req_b_reg] = req_b_data;
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        req_a_valid = 1'b0;
        req_b_valid = 1'b0;
    endtask

    task automatic drive_a(input logic [SEL_W-1:0] r, input logic [DATA_W-1:0] d);
        req_a_valid = 1'b1; req_a_reg = r; req_a_data = d;
    endtask

    task automatic drive_b(input logic [SEL_W-1:0] r, input logic [DATA_W-1:0] d);
        req_b_valid = 1'b1; req_b_reg = r; req_b_data = d;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        req_a_reg = '0; req_a_data = '0; req_b_reg = '0; req_b_data = '0;
        read1_reg_sel = '0; read2_reg_sel = '0;
        #3;
        chk("rst_ready_a", 32'(req_a_ready), 32'd1);
        chk("rst_ready_b", 32'(req_b_ready), 32'd1);
        chk("rst_rf_write", 32'(rf_write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pend1", 32'(pend1_hit), 32'd0);
        #9 rst_n = 1'b1;

        // A writes R3 = 0x1234
        next();
        drive_a(3'd3, 16'h1234);
        next();
        idle();
        read1_reg_sel = 3'd3;
        at_neg();
        chk("t1_write", 32'(rf_write), 32'd1);
        chk("t1_sel", 32'(rf_write_reg_sel), 32'd3);
        chk("t1_data", 32'(rf_write_data), 32'h1234);
        chk("t1_hit", 32'(pend1_hit), 32'd1);
        chk("t1_fwd", 32'(pend1_data), 32'h1234);
        next();
        at_neg();
        chk("t1_busy", 32'(busy), 32'd0);

        // Both requesters saturate with different registers
        for (int k = 0; k < 9; k++) begin
            next();
            drive_a(3'd1, 16'($urandom));
            drive_b(3'd6, 16'($urandom));
            at_neg();
            if (k >= 1) begin
                chk("t2_grant_sel", 32'(rf_write_reg_sel), (k % 4 == 0) ? 32'd6 : 32'd1);
                chk("t2_ready_b", 32'(req_b_ready), (k % 4 == 0) ? 32'd1 : 32'd0);
            end
        end
        next();
        idle();
        repeat (4) next();

        // Same-edge acceptance to R5
        drive_a(3'd5, 16'h0001);
        drive_b(3'd5, 16'h0002);
        next();
        idle();
        read1_reg_sel = 3'd5;
        at_neg();
        chk("t3_first", 32'(rf_write_data), 32'h0001);
        chk("t3_fwd", 32'(pend1_data), 32'h0002);
        next();
        at_neg();
        chk("t3_second", 32'(rf_write_data), 32'h0002);
        next();
        at_neg();
        chk("t3_rf5", 32'(model_rf[5]), 32'h0002);

        // A older on R2 wins over B despite starvation history
        next();
        drive_a(3'd1, 16'h0101);
        drive_b(3'd7, 16'h0707);
        next();
        req_b_valid = 1'b0;
        drive_a(3'd1, 16'h0102);
        next();
        drive_a(3'd1, 16'h0103);
        next();
        drive_a(3'd2, 16'hAAAA);
        next();
        req_a_valid = 1'b0;
        drive_b(3'd2, 16'hBBBB);
        at_neg();
        chk("t4_b_starved", 32'(rf_write_reg_sel), 32'd7);
        next();
        idle();
        read2_reg_sel = 3'd2;
        at_neg();
        chk("t4_a_first", 32'(rf_write_data), 32'hAAAA);
        chk("t4_fwd_young", 32'(pend2_data), 32'hBBBB);
        next();
        at_neg();
        chk("t4_b_second", 32'(rf_write_data), 32'hBBBB);
        next();
        at_neg();
        chk("t4_rf2", 32'(model_rf[2]), 32'hBBBB);

        // Asynchronous reset with both buffers full
        next();
        drive_a(3'd4, 16'h4444);
        drive_b(3'd6, 16'h6666);
        next();
        idle();
        read1_reg_sel = 3'd4;
        read2_reg_sel = 3'd6;
        #1 rst_n = 1'b0;
        #1;
        chk("t5_write", 32'(rf_write), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ready_a", 32'(req_a_ready), 32'd1);
        chk("t5_ready_b", 32'(req_b_ready), 32'd1);
        chk("t5_hit1", 32'(pend1_hit), 32'd0);
        chk("t5_data2", 32'(pend2_data), 32'd0);
        q.delete();
        wait_b = 0;
        for (int i = 0; i < 8; i++) prog_rf[i] = model_rf[i];
        @(posedge clk);
        #3 rst_n = 1'b1;
        at_neg();
        chk("t5_post_write", 32'(rf_write), 32'd0);
        chk("t5_post_ready", 32'(req_a_ready), 32'd1);

        // Random traffic
        for (int n = 0; n < 1000; n++) begin
            next();
            req_a_valid   = ($urandom_range(0, 99) < 60);
            req_b_valid   = ($urandom_range(0, 99) < 60);
            req_a_reg     = 3'($urandom_range(0, 7));
            req_b_reg     = ($urandom_range(0, 3) == 0) ? req_a_reg : 3'($urandom_range(0, 7));
            req_a_data    = 16'($urandom);
            req_b_data    = 16'($urandom);
            read1_reg_sel = 3'($urandom_range(0, 7));
            read2_reg_sel = ($urandom_range(0, 1) == 0) ? req_a_reg : 3'($urandom_range(0, 7));
        end
        next();
        idle();
        repeat (6) next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
